i2c_peripheral: RTL and testbench

I2C target (responder) that answers a controller on the shared `sdc`/`sda` bus at a single fixed 7-bit address. It oversamples both bus lines with the system clock, detects START and STOP conditions, and matches the address byte. On a controller write it receives bytes into `rx_byte`; on a controller read it transmits `tx_byte`. It is the bus-side endpoint for on-board peripherals and the loop-back partner for bench testing of the controller.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_line_sync.sv | 65 ++++++
 rtl/i2c_peripheral.sv | 199 +++++++++++++++++++
 tb/tb_i2c_peripheral.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, transfer mode constants and bit-count helpers.
// Used by both the peripheral and the controller.
package i2c_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_RX_BYTE   = 4'd3;
  localparam logic [3:0] ST_RX_ACK    = 4'd4;
  localparam logic [3:0] ST_TX_BYTE   = 4'd5;
  localparam logic [3:0] ST_TX_ACK    = 4'd6;
  localparam logic [3:0] ST_WAIT_STOP = 4'd7;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [CNT_W-1:0] BYTE_BITS = 4'd8;
  localparam logic [CNT_W-1:0] ACK_BIT   = 4'd9;

  // Saturating bit-counter increment.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line front end: 2-flop synchronizer, optional glitch filter, registered rise/fall detect.
// Filter is enabled with `define I2C_PERIPH_FILTER_EN.
module i2c_line_sync
`ifdef I2C_PERIPH_FILTER_EN
#(
  parameter int unsigned FILTER_DEPTH = 3
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       clean;

  // Bus lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], line};
  end

`ifdef I2C_PERIPH_FILTER_EN
  localparam int unsigned RUN_W = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

  logic [RUN_W-1:0] run;
  logic             filt;

  // Accept a new level only after FILTER_DEPTH consecutive samples of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      run  <= '0;
    end else if (sync[1] == filt) begin
      run <= '0;
    end else if (32'(run) + 32'd1 >= FILTER_DEPTH) begin
      filt <= sync[1];
      run  <= '0;
    end else begin
      run <= run + RUN_W'(1);
    end
  end

  assign clean = filt;
`else
  assign clean = sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= clean;
      rise  <= clean & ~level;
      fall  <= ~clean & level;
    end
  end

endmodule

// File: rtl/i2c_peripheral.sv
// I2C target at a fixed 7-bit address: receives write bytes into rx_byte, returns tx_byte on reads.
// `define I2C_PERIPH_FILTER_EN inserts a FILTER_DEPTH-sample glitch filter on both bus lines.
module i2c_peripheral
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h42
`ifdef I2C_PERIPH_FILTER_EN
  , parameter int unsigned FILTER_DEPTH = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdc,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy
);

  logic sdc_level, sdc_rise, sdc_fall;
  logic sda_level, sda_rise, sda_fall;

`ifdef I2C_PERIPH_FILTER_EN
  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_sdc_sync (
    .clk(clk), .reset(reset), .line(sdc), .level(sdc_level), .rise(sdc_rise), .fall(sdc_fall));
  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_sync (
    .clk(clk), .reset(reset), .line(sda), .level(sda_level), .rise(sda_rise), .fall(sda_fall));
`else
  i2c_line_sync u_sdc_sync (
    .clk(clk), .reset(reset), .line(sdc), .level(sdc_level), .rise(sdc_rise), .fall(sdc_fall));
  i2c_line_sync u_sda_sync (
    .clk(clk), .reset(reset), .line(sda), .level(sda_level), .rise(sda_rise), .fall(sda_fall));
`endif

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [7:0]         shift, shift_d;
  logic [7:0]         rx_byte_d;
  logic               drive, drive_d;
  logic               busy_d, rx_valid_d, tx_load_d;
  logic               start, stop, rw_mode;

  // Open-drain: only ever pull low; reset clears drive asynchronously.
  assign sda     = drive ? 1'b0 : 1'bz;
  assign start   = sda_fall & sdc_level;
  assign stop    = sda_rise & sdc_level;
  assign rw_mode = shift[0] ? READ : WRITE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shift    <= '0;
      drive    <= 1'b0;
      busy     <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      shift    <= shift_d;
      drive    <= drive_d;
      busy     <= busy_d;
      rx_byte  <= rx_byte_d;
      rx_valid <= rx_valid_d;
      tx_load  <= tx_load_d;
    end
  end

  // Bus conditions take priority over any sdc edge seen in the same cycle.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    shift_d    = shift;
    drive_d    = drive;
    busy_d     = busy;
    rx_byte_d  = rx_byte;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT_STOP: begin
          drive_d = 1'b0;
        end

        ST_ADDR: begin
          if (sdc_rise) begin
            shift_d = {shift[6:0], sda_level};
            cnt_d   = cnt_inc(cnt);
            if (cnt_d == BYTE_BITS) begin
              if (shift_d[7:1] == ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // ACK spans 8th fall to 9th fall; cnt moves 8 -> 9 on the ACK clock pulse.
        ST_ADDR_ACK: begin
          if (sdc_rise) begin
            cnt_d = cnt_inc(cnt);
          end else if (sdc_fall) begin
            if (cnt == BYTE_BITS) begin
              drive_d = 1'b1;
            end else if (cnt == ACK_BIT) begin
              cnt_d = '0;
              if (rw_mode == READ) begin
                tx_load_d = 1'b1;
                shift_d   = tx_byte;
                drive_d   = ~tx_byte[7];
                state_d   = ST_TX_BYTE;
              end else begin
                drive_d = 1'b0;
                state_d = ST_RX_BYTE;
              end
            end
          end
        end

        ST_RX_BYTE: begin
          if (sdc_rise) begin
            shift_d = {shift[6:0], sda_level};
            cnt_d   = cnt_inc(cnt);
            if (cnt_d == BYTE_BITS) begin
              rx_byte_d  = shift_d;
              rx_valid_d = 1'b1;
              state_d    = ST_RX_ACK;
            end
          end
        end

        ST_RX_ACK: begin
          if (sdc_rise) begin
            cnt_d = cnt_inc(cnt);
          end else if (sdc_fall) begin
            if (cnt == BYTE_BITS) begin
              drive_d = 1'b1;
            end else if (cnt == ACK_BIT) begin
              cnt_d   = '0;
              drive_d = 1'b0;
              state_d = ST_RX_BYTE;
            end
          end
        end

        // MSB of shift is always the bit on the bus; it advances on each rise.
        ST_TX_BYTE: begin
          if (sdc_rise) begin
            shift_d = {shift[6:0], 1'b0};
            cnt_d   = cnt_inc(cnt);
          end else if (sdc_fall) begin
            if (cnt == BYTE_BITS) begin
              drive_d = 1'b0;
              state_d = ST_TX_ACK;
            end else begin
              drive_d = ~shift[7];
            end
          end
        end

        ST_TX_ACK: begin
          if (sdc_rise) begin
            if (!sda_level) begin
              tx_load_d = 1'b1;
              shift_d   = tx_byte;
              cnt_d     = '0;
              state_d   = ST_TX_BYTE;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_peripheral.sv
// Self-checking bench for i2c_peripheral: a bus-level controller model plus randomized transactions
// compared against expectations derived from the address/direction/byte sequence of each transfer.
module tb_i2c_peripheral;

  localparam logic [6:0] ADDR = 7'h42;
  localparam int         Q    = 5;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       sdc_drv = 1'b1;
  logic       sda_low = 1'b0;
  logic [7:0] tx_byte;
  wire        sda;
  wire        tx_load, rx_valid, busy;
  wire  [7:0] rx_byte;

  int n_checks = 0;
  int n_fail   = 0;

  int         rx_pulses = 0;
  int         tx_loads  = 0;
  int         overlaps  = 0;
  int         dut_lows  = 0;
  int         tx_base   = 0;
  logic [7:0] rx_seen[$];
  logic [7:0] tx_plan[$];

  always #5 clk = ~clk;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_peripheral #(.ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .sdc(sdc_drv), .sda(sda),
    .tx_byte(tx_byte), .tx_load(tx_load), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .busy(busy)
  );

  // Pulse bookkeeping and tx_byte supply: each load advances to the next planned byte.
  always @(negedge clk) begin
    int idx;
    if (rx_valid) begin
      rx_pulses++;
      rx_seen.push_back(rx_byte);
    end
    if (tx_load) tx_loads++;
    if (rx_valid && tx_load) overlaps++;
    if (!sda_low && sda === 1'b0) dut_lows++;
    idx     = tx_loads - tx_base;
    tx_byte = (idx >= 0 && idx < tx_plan.size()) ? tx_plan[idx] : 8'hFF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (!sdc_drv) begin
      sda_low = 1'b0; wait_clk(Q);
      sdc_drv = 1'b1; wait_clk(Q);
    end
    sda_low = 1'b1; wait_clk(2 * Q);
    sdc_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wait_clk(Q);
    sdc_drv = 1'b1; wait_clk(Q);
    sda_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;   wait_clk(Q);
    sdc_drv = 1'b1; wait_clk(2 * Q);
    sdc_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_low = 1'b0; wait_clk(Q);
    sdc_drv = 1'b1; wait_clk(Q);
    b = (sda !== 1'b0);
    wait_clk(Q);
    sdc_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(nack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       nack;
    logic [7:0] got;
    int         rx0, tx0, low0;

    wait_clk(4);
    check("reset_sda_released", 32'(sda !== 1'b0), 1);
    check("reset_rx_byte", 32'(rx_byte), 8'h00);
    check("reset_busy", 32'(busy), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_tx_load", 32'(tx_load), 0);
    reset = 1'b0;
    wait_clk(4);

    // Write 0xA5 to 0x42.
    rx0 = rx_pulses;
    bus_start();
    send_byte(8'h84, nack); check("wr_addr_ack", 32'(nack), 0);
    check("wr_busy_after_match", 32'(busy), 1);
    send_byte(8'hA5, nack); check("wr_data_ack", 32'(nack), 0);
    bus_stop();
    check("wr_rx_pulses", 32'(rx_pulses - rx0), 1);
    check("wr_rx_byte", 32'(rx_byte), 8'hA5);
    check("wr_busy_after_stop", 32'(busy), 0);

    // Single-byte read with NACK.
    tx_plan = '{8'h3C}; tx_base = tx_loads; tx0 = tx_loads;
    wait_clk(2);
    bus_start();
    send_byte(8'h85, nack); check("rd_addr_ack", 32'(nack), 0);
    recv_byte(got, 1'b1);   check("rd_byte", 32'(got), 8'h3C);
    check("rd_busy_before_stop", 32'(busy), 1);
    check("rd_sda_released_after_nack", 32'(sda !== 1'b0), 1);
    bus_stop();
    check("rd_tx_loads", 32'(tx_loads - tx0), 1);
    check("rd_busy_after_stop", 32'(busy), 0);

    // Two-byte read, tx_byte changes between loads.
    tx_plan = '{8'h11, 8'h22}; tx_base = tx_loads; tx0 = tx_loads;
    wait_clk(2);
    bus_start();
    send_byte(8'h85, nack); check("rd2_addr_ack", 32'(nack), 0);
    recv_byte(got, 1'b0);   check("rd2_byte0", 32'(got), 8'h11);
    recv_byte(got, 1'b1);   check("rd2_byte1", 32'(got), 8'h22);
    bus_stop();
    check("rd2_tx_loads", 32'(tx_loads - tx0), 2);

    // Wrong address: never pulls sda, no pulses, not busy.
    rx0 = rx_pulses; tx0 = tx_loads; low0 = dut_lows;
    bus_start();
    send_byte(8'hA0, nack); check("bad_addr_nack", 32'(nack), 1);
    check("bad_addr_busy", 32'(busy), 0);
    send_byte(8'h5A, nack); check("bad_addr_data_nack", 32'(nack), 1);
    bus_stop();
    check("bad_addr_no_drive", 32'(dut_lows - low0), 0);
    check("bad_addr_no_pulses", 32'(rx_pulses - rx0 + tx_loads - tx0), 0);

    // Repeated START after a write byte, then a read.
    rx0 = rx_pulses; tx_plan = '{8'hC7}; tx_base = tx_loads; tx0 = tx_loads;
    wait_clk(2);
    bus_start();
    send_byte(8'h84, nack); check("rs_addr_w_ack", 32'(nack), 0);
    send_byte(8'h69, nack); check("rs_data_ack", 32'(nack), 0);
    bus_start();
    check("rs_busy_cleared", 32'(busy), 0);
    send_byte(8'h85, nack); check("rs_addr_r_ack", 32'(nack), 0);
    recv_byte(got, 1'b1);   check("rs_rd_byte", 32'(got), 8'hC7);
    bus_stop();
    check("rs_rx_byte", 32'(rx_byte), 8'h69);
    check("rs_counts", 32'(rx_pulses - rx0 + 4 * (tx_loads - tx0)), 5);

    // Reset while the address ACK is being driven: release must be immediate.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(ADDR[(i == 0) ? 0 : i - 1] & (i != 0));
    sda_low = 1'b0; wait_clk(1);
    check("ack_driven_before_reset", 32'(sda === 1'b0), 1);
    reset = 1'b1; #1;
    check("ack_released_on_reset", 32'(sda !== 1'b0), 1);
    wait_clk(2); reset = 1'b0; wait_clk(2);
    bus_stop();

    // Reset during data bit 4 of a write byte.
    rx0 = rx_pulses;
    bus_start();
    send_byte(8'h84, nack); check("rst_addr_ack", 32'(nack), 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    sda_low = 1'b0; wait_clk(Q);
    sdc_drv = 1'b1; wait_clk(Q);
    reset = 1'b1; #1;
    check("rst_sda_released", 32'(sda !== 1'b0), 1);
    check("rst_rx_byte", 32'(rx_byte), 8'h00);
    check("rst_busy", 32'(busy), 0);
    wait_clk(2); reset = 1'b0;
    sdc_drv = 1'b0; wait_clk(Q);
    bus_stop();
    check("rst_no_pulse", 32'(rx_pulses - rx0), 0);
    rx0 = rx_pulses;
    bus_start();
    send_byte(8'h84, nack); check("post_rst_addr_ack", 32'(nack), 0);
    send_byte(8'h5A, nack); check("post_rst_data_ack", 32'(nack), 0);
    bus_stop();
    check("post_rst_rx_byte", 32'(rx_byte), 8'h5A);
    check("post_rst_rx_pulses", 32'(rx_pulses - rx0), 1);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      logic       rw, match;
      int         n;
      logic [7:0] exp_q[$];
      a     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
      rw    = 1'($urandom);
      n     = $urandom_range(1, 3);
      match = (a == ADDR);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      rx0 = rx_pulses; tx0 = tx_loads; low0 = dut_lows;
      if (rw) begin tx_plan = exp_q; tx_base = tx_loads; end
      wait_clk(2);
      bus_start();
      send_byte({a, rw}, nack);
      check("rnd_addr_ack", 32'(nack), 32'(!match));
      check("rnd_busy", 32'(busy), 32'(match));
      if (match && rw) begin
        for (int i = 0; i < n; i++) begin
          recv_byte(got, i == n - 1);
          check("rnd_rd_byte", 32'(got), 32'(exp_q[i]));
        end
      end else if (!rw) begin
        for (int i = 0; i < n; i++) begin
          send_byte(exp_q[i], nack);
          check("rnd_wr_ack", 32'(nack), 32'(!match));
        end
      end
      bus_stop();
      check("rnd_busy_after_stop", 32'(busy), 0);
      check("rnd_rx_pulses", 32'(rx_pulses - rx0), (match && !rw) ? 32'(n) : 0);
      check("rnd_tx_loads", 32'(tx_loads - tx0), (match && rw) ? 32'(n) : 0);
      if (!match) check("rnd_no_drive", 32'(dut_lows - low0), 0);
      if (match && !rw) begin
        for (int i = 0; i < n; i++) begin
          logic [7:0] seen;
          seen = (rx0 + i < rx_seen.size()) ? rx_seen[rx0 + i] : 8'hXX;
          check("rnd_rx_data", 32'(seen), 32'(exp_q[i]));
        end
      end
    end

    check("pulse_overlap", 32'(overlaps), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
